crack_sequencer: RTL and testbench

- Top-level sequencer for the password-recovery flow.
- Walks the dictionary region of the candidate BRAM, then a brute-force counter range.
- Hands each candidate to the AES encrypt core over a valid/ready request with a valid-only response.
- Compares each result with the latched target hash and reports SUCCESS or FAIL on `state` and `led`.
- Replaces the ad-hoc state logic in the cracker top with one handshake-clean FSM.

---
 rtl/crack_pkg.sv | 19 +
 rtl/crack_cand_src.sv | 55 +++++
 rtl/crack_sequencer.sv | 126 ++++++++++++
 tb/tb_crack_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// crack_pkg: state, phase and LED encodings shared by the password-recovery sequencer
package crack_pkg;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_DICT    = 3'd2,
        ST_BRUTE   = 3'd3,
        ST_SUCCESS = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;
    typedef enum logic [1:0] {PH_RD, PH_CAP, PH_REQ, PH_WAIT} phase_t;
    localparam logic [2:0] LED_WAIT = 3'b011;
    localparam logic [2:0] LED_BUSY = 3'b100;
    localparam logic [2:0] LED_OK   = 3'b010;
    localparam logic [2:0] LED_FAIL = 3'b001;
    function automatic logic [2:0] led_of(state_t s);
        return s == ST_IDLE ? LED_WAIT : s == ST_SUCCESS ? LED_OK : s == ST_FAIL ? LED_FAIL : LED_BUSY;
    endfunction
endpackage

// File: rtl/crack_cand_src.sv
// crack_cand_src: dictionary/brute candidate generator with BRAM read port and last-candidate flag
module crack_cand_src #(
    parameter int DICT_START     = 1,
    parameter int DICT_SIZE      = 3,
    parameter int BRUTE_ATTEMPTS = 10,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_init,
    input  logic              i_brute,
    input  logic              i_rd,
    input  logic              i_cap,
    input  logic              i_brute_init,
    input  logic              i_adv,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_cand,
    output logic              o_last
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DICT_SIZE - 1);
    localparam logic [31:0]       LAST_CNT = 32'(BRUTE_ATTEMPTS - 1);
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_cnt;
    logic [DATA_W-1:0] r_cand;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx  <= '0;
            r_cnt  <= '0;
            r_cand <= '0;
        end else begin
            if (i_init)
                r_idx <= '0;
            else if (i_adv && !i_brute)
                r_idx <= r_idx + ADDR_W'(1);
            if (i_brute_init)
                r_cnt <= '0;
            else if (i_adv && i_brute)
                r_cnt <= r_cnt + 32'd1;
            // brute candidate is loaded on entry to REQ, i.e. alongside the counter step
            if (i_cap)
                r_cand <= i_mem_rdata;
            else if (i_brute_init)
                r_cand <= '0;
            else if (i_adv && i_brute)
                r_cand <= DATA_W'(r_cnt + 32'd1);
        end
    end
    assign o_mem_en   = i_rd;
    assign o_mem_addr = i_rd ? ADDR_W'(DICT_START) + r_idx : '0;
    assign o_cand     = r_cand;
    assign o_last     = i_brute ? r_cnt == LAST_CNT : r_idx == LAST_IDX;
endmodule

// File: rtl/crack_sequencer.sv
// crack_sequencer: dictionary-then-brute password-recovery FSM driving an encrypt core
module crack_sequencer
    import crack_pkg::*;
#(
    parameter int DICT_START     = 1,
    parameter int DICT_SIZE      = 3,
    parameter int BRUTE_ATTEMPTS = 10,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] target_hash,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              enc_req_valid,
    input  logic              enc_req_ready,
    output logic [DATA_W-1:0] enc_req_data,
    input  logic              enc_rsp_valid,
    input  logic [DATA_W-1:0] enc_rsp_data,
    output logic [2:0]        state,
    output logic [2:0]        led,
    output logic [DATA_W-1:0] found,
    output logic [31:0]       attempts
);
    state_t            r_state, w_state_nxt;
    phase_t            r_phase, w_phase_nxt;
    logic [2:0]        r_led;
    logic [DATA_W-1:0] r_hash, r_found, w_cand;
    logic [31:0]       r_attempts;
    logic              w_run, w_brute, w_rsp, w_hit, w_last;
    logic              w_init, w_rd, w_cap, w_req, w_adv, w_brute_init;
    assign w_run   = r_state == ST_DICT || r_state == ST_BRUTE;
    assign w_brute = r_state == ST_BRUTE;
    assign w_rsp   = w_run && r_phase == PH_WAIT && enc_rsp_valid;
    assign w_hit   = w_rsp && enc_rsp_data == r_hash;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_phase <= PH_RD;
            r_led   <= LED_WAIT;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_led   <= led_of(w_state_nxt);
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_state_nxt = DICT_SIZE > 0 ? ST_DICT : BRUTE_ATTEMPTS > 0 ? ST_BRUTE : ST_FAIL;
                w_phase_nxt = DICT_SIZE > 0 ? PH_RD : PH_REQ;
            end
            ST_DICT, ST_BRUTE: case (r_phase)
                PH_RD:   w_phase_nxt = PH_CAP;
                PH_CAP:  w_phase_nxt = PH_REQ;
                PH_REQ:  if (enc_req_ready) w_phase_nxt = PH_WAIT;
                PH_WAIT: if (enc_rsp_valid) begin
                    if (w_hit)
                        w_state_nxt = ST_SUCCESS;
                    else if (w_last)
                        w_state_nxt = r_state == ST_DICT && BRUTE_ATTEMPTS > 0 ? ST_BRUTE : ST_FAIL;
                    w_phase_nxt = r_state == ST_DICT && !w_last ? PH_RD : PH_REQ;
                end
            endcase
            default: ;
        endcase
    end
    always_comb begin
        w_init       = r_state == ST_IDLE && start;
        w_rd         = r_state == ST_DICT && r_phase == PH_RD;
        w_cap        = r_state == ST_DICT && r_phase == PH_CAP;
        w_req        = w_run && r_phase == PH_REQ;
        w_adv        = w_rsp && !w_hit;
        w_brute_init = w_state_nxt == ST_BRUTE && r_state != ST_BRUTE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hash     <= '0;
            r_found    <= '0;
            r_attempts <= '0;
        end else begin
            if (w_init) begin
                r_hash     <= target_hash;
                r_found    <= '0;
                r_attempts <= '0;
            end
            if (w_rsp && r_attempts != '1)
                r_attempts <= r_attempts + 32'd1;
            if (w_hit)
                r_found <= w_cand;
        end
    end
    crack_cand_src #(
        .DICT_START    (DICT_START),
        .DICT_SIZE     (DICT_SIZE),
        .BRUTE_ATTEMPTS(BRUTE_ATTEMPTS),
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W)
    ) u_src (
        .clk         (clk),
        .reset       (reset),
        .i_init      (w_init),
        .i_brute     (w_brute),
        .i_rd        (w_rd),
        .i_cap       (w_cap),
        .i_brute_init(w_brute_init),
        .i_adv       (w_adv),
        .i_mem_rdata (mem_rdata),
        .o_mem_en    (mem_en),
        .o_mem_addr  (mem_addr),
        .o_cand      (w_cand),
        .o_last      (w_last)
    );
    assign enc_req_valid = w_req;
    assign enc_req_data  = w_cand;
    assign state         = r_state;
    assign led           = r_led;
    assign found         = r_found;
    assign attempts      = r_attempts;
endmodule

// File: tb/tb_crack_sequencer.sv
// tb_crack_sequencer: directed checks with an identity encrypt core (L=2) and a small BRAM model
module tb_crack_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic         reset = 1'b0, start = 1'b0, enc_req_ready = 1'b1;
    logic [127:0] target_hash = '0;
    logic         mem_en, enc_req_valid;
    logic [7:0]   mem_addr;
    logic [127:0] mem_rdata = '0, enc_req_data, found;
    logic         enc_rsp_valid = 1'b0, p1 = 1'b0;
    logic [127:0] enc_rsp_data = '0, d1 = '0;
    logic [2:0]   state, led;
    logic [31:0]  attempts;
    logic         d_start = 1'b0, d_mem_en, d_req_valid;
    logic [7:0]   d_mem_addr;
    logic [127:0] d_req_data, d_found;
    logic [2:0]   d_state, d_led;
    logic [31:0]  d_attempts;
    logic [127:0] bram [256];
    logic [127:0] last_req = '0;
    logic [7:0]   seen;
    int n_checks = 0, n_pass = 0, n_xfer = 0, d_pulses = 0;

    crack_sequencer #(.DICT_START(1), .DICT_SIZE(3), .BRUTE_ATTEMPTS(10), .ADDR_W(8), .DATA_W(128)) dut (
        .clk(clk), .reset(reset), .start(start), .target_hash(target_hash),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .enc_req_valid(enc_req_valid), .enc_req_ready(enc_req_ready), .enc_req_data(enc_req_data),
        .enc_rsp_valid(enc_rsp_valid), .enc_rsp_data(enc_rsp_data),
        .state(state), .led(led), .found(found), .attempts(attempts));

    crack_sequencer #(.DICT_START(1), .DICT_SIZE(0), .BRUTE_ATTEMPTS(0), .ADDR_W(8), .DATA_W(128)) dut_deg (
        .clk(clk), .reset(reset), .start(d_start), .target_hash(target_hash),
        .mem_en(d_mem_en), .mem_addr(d_mem_addr), .mem_rdata(128'h0),
        .enc_req_valid(d_req_valid), .enc_req_ready(1'b1), .enc_req_data(d_req_data),
        .enc_rsp_valid(1'b0), .enc_rsp_data(128'h0),
        .state(d_state), .led(d_led), .found(d_found), .attempts(d_attempts));

    // BRAM with one-cycle read latency and an identity core with two-cycle latency; neither resets
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= bram[mem_addr];
        p1            <= enc_req_valid && enc_req_ready;
        d1            <= enc_req_data;
        enc_rsp_valid <= p1;
        enc_rsp_data  <= d1;
    end
    always @(posedge clk) begin
        if (enc_req_valid && enc_req_ready) begin
            n_xfer   = n_xfer + 1;
            last_req = enc_req_data;
        end
        if (d_mem_en || d_req_valid) d_pulses = d_pulses + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        start = 1'b0;
        enc_req_ready = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    task automatic do_start(input logic [127:0] t);
        target_hash = t;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_terminal(input int max_cyc);
        for (int i = 0; i < max_cyc && state != 3'd4 && state != 3'd5; i++) begin
            tick;
            seen[state] = 1'b1;
        end
        n_checks++; if (state != 3'd4 && state != 3'd5) $display("FAIL terminal_timeout state=%0d after %0d cycles want 4 or 5", state, max_cyc); else n_pass++;
    endtask

    task automatic test_reset;
        apply_reset;
        n_checks++; if (state !== 3'd0) $display("FAIL rst_state got %0d want 0", state); else n_pass++;
        n_checks++; if (led !== 3'b011) $display("FAIL rst_led got %b want 011", led); else n_pass++;
        n_checks++; if (mem_en !== 1'b0) $display("FAIL rst_mem_en got %b want 0", mem_en); else n_pass++;
        n_checks++; if (mem_addr !== 8'd0) $display("FAIL rst_mem_addr got %0h want 0", mem_addr); else n_pass++;
        n_checks++; if (enc_req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", enc_req_valid); else n_pass++;
        n_checks++; if (enc_req_data !== 128'h0) $display("FAIL rst_req_data got %0h want 0", enc_req_data); else n_pass++;
        n_checks++; if (found !== 128'h0) $display("FAIL rst_found got %0h want 0", found); else n_pass++;
        n_checks++; if (attempts !== 32'd0) $display("FAIL rst_attempts got %0d want 0", attempts); else n_pass++;
    endtask

    task automatic test_dict_hit;
        apply_reset;
        do_start(128'hA2);
        n_checks++; if (state !== 3'd1) $display("FAIL dict_load_state got %0d want 1", state); else n_pass++;
        n_checks++; if (led !== 3'b100) $display("FAIL dict_load_led got %b want 100", led); else n_pass++;
        wait_terminal(200);
        n_checks++; if (state !== 3'd4) $display("FAIL dict_state got %0d want 4", state); else n_pass++;
        n_checks++; if (found !== 128'hA2) $display("FAIL dict_found got %0h want a2", found); else n_pass++;
        n_checks++; if (attempts !== 32'd2) $display("FAIL dict_attempts got %0d want 2", attempts); else n_pass++;
        n_checks++; if (led !== 3'b010) $display("FAIL dict_led got %b want 010", led); else n_pass++;
    endtask

    task automatic test_brute_hit;
        apply_reset;
        seen = '0;
        do_start(128'h5);
        wait_terminal(300);
        n_checks++; if (seen[2] !== 1'b1) $display("FAIL brute_saw_dict got %b want 1", seen[2]); else n_pass++;
        n_checks++; if (seen[3] !== 1'b1) $display("FAIL brute_saw_brute got %b want 1", seen[3]); else n_pass++;
        n_checks++; if (state !== 3'd4) $display("FAIL brute_state got %0d want 4", state); else n_pass++;
        n_checks++; if (found !== 128'h5) $display("FAIL brute_found got %0h want 5", found); else n_pass++;
        n_checks++; if (attempts !== 32'd9) $display("FAIL brute_attempts got %0d want 9", attempts); else n_pass++;
    endtask

    task automatic test_full_miss;
        int base;
        apply_reset;
        base = n_xfer;
        do_start(128'hFFFF);
        wait_terminal(400);
        n_checks++; if (state !== 3'd5) $display("FAIL miss_state got %0d want 5", state); else n_pass++;
        n_checks++; if (led !== 3'b001) $display("FAIL miss_led got %b want 001", led); else n_pass++;
        n_checks++; if (attempts !== 32'd13) $display("FAIL miss_attempts got %0d want 13", attempts); else n_pass++;
        n_checks++; if (last_req !== 128'h9) $display("FAIL miss_last_req got %0h want 9", last_req); else n_pass++;
        n_checks++; if (n_xfer - base !== 13) $display("FAIL miss_xfers got %0d want 13", n_xfer - base); else n_pass++;
        n_checks++; if (found !== 128'h0) $display("FAIL miss_found got %0h want 0", found); else n_pass++;
        do_start(128'hA1);
        for (int i = 0; i < 8; i++) tick;
        n_checks++; if (state !== 3'd5) $display("FAIL miss_sticky got %0d want 5", state); else n_pass++;
        n_checks++; if (enc_req_valid !== 1'b0) $display("FAIL miss_req_valid got %b want 0", enc_req_valid); else n_pass++;
        n_checks++; if (mem_en !== 1'b0) $display("FAIL miss_mem_en got %b want 0", mem_en); else n_pass++;
    endtask

    task automatic test_backpressure;
        int base;
        logic [127:0] held;
        bit got;
        apply_reset;
        base = n_xfer;
        got = 1'b0;
        do_start(128'hA2);
        for (int i = 0; i < 100 && !got; i++) begin
            if (n_xfer - base == 1 && enc_req_valid) got = 1'b1;
            else tick;
        end
        n_checks++; if (!got) $display("FAIL bp_second_req_timeout xfers=%0d want 1 then valid", n_xfer - base); else n_pass++;
        enc_req_ready = 1'b0;
        held = enc_req_data;
        n_checks++; if (held !== 128'hA2) $display("FAIL bp_req_data got %0h want a2", held); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_checks++; if (enc_req_valid !== 1'b1) $display("FAIL bp_valid_held cycle %0d got %b want 1", i, enc_req_valid); else n_pass++;
            n_checks++; if (enc_req_data !== held) $display("FAIL bp_data_held cycle %0d got %0h want %0h", i, enc_req_data, held); else n_pass++;
        end
        n_checks++; if (n_xfer - base !== 1) $display("FAIL bp_no_xfer got %0d want 1", n_xfer - base); else n_pass++;
        enc_req_ready = 1'b1;
        wait_terminal(200);
        n_checks++; if (n_xfer - base !== 2) $display("FAIL bp_total_xfers got %0d want 2", n_xfer - base); else n_pass++;
        n_checks++; if (state !== 3'd4) $display("FAIL bp_state got %0d want 4", state); else n_pass++;
        n_checks++; if (found !== 128'hA2) $display("FAIL bp_found got %0h want a2", found); else n_pass++;
        n_checks++; if (attempts !== 32'd2) $display("FAIL bp_attempts got %0d want 2", attempts); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit got;
        apply_reset;
        got = 1'b0;
        do_start(128'hFFFF);
        for (int i = 0; i < 200 && !got; i++) begin
            if (state == 3'd3 && enc_req_valid) got = 1'b1;
            else tick;
        end
        n_checks++; if (!got) $display("FAIL rmid_brute_timeout state=%0d want 3 with valid", state); else n_pass++;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n_checks++; if (state !== 3'd0) $display("FAIL rmid_state got %0d want 0", state); else n_pass++;
        n_checks++; if (led !== 3'b011) $display("FAIL rmid_led got %b want 011", led); else n_pass++;
        n_checks++; if (attempts !== 32'd0) $display("FAIL rmid_attempts got %0d want 0", attempts); else n_pass++;
        n_checks++; if (enc_req_valid !== 1'b0) $display("FAIL rmid_req_valid got %b want 0", enc_req_valid); else n_pass++;
        n_checks++; if (enc_rsp_valid !== 1'b1) $display("FAIL rmid_late_rsp got %b want 1", enc_rsp_valid); else n_pass++;
        tick;
        n_checks++; if (state !== 3'd0) $display("FAIL rmid_late_state got %0d want 0", state); else n_pass++;
        n_checks++; if (attempts !== 32'd0) $display("FAIL rmid_late_attempts got %0d want 0", attempts); else n_pass++;
    endtask

    task automatic test_start_ignored;
        bit got;
        apply_reset;
        got = 1'b0;
        do_start(128'hA3);
        for (int i = 0; i < 20 && !got; i++) begin
            if (state == 3'd2) got = 1'b1;
            else tick;
        end
        n_checks++; if (!got) $display("FAIL sig_dict_timeout state=%0d want 2", state); else n_pass++;
        do_start(128'hA1);
        wait_terminal(200);
        n_checks++; if (state !== 3'd4) $display("FAIL sig_state got %0d want 4", state); else n_pass++;
        n_checks++; if (found !== 128'hA3) $display("FAIL sig_found got %0h want a3", found); else n_pass++;
        n_checks++; if (attempts !== 32'd3) $display("FAIL sig_attempts got %0d want 3", attempts); else n_pass++;
    endtask

    task automatic test_start_reset;
        reset = 1'b1;
        start = 1'b1;
        target_hash = 128'hA1;
        tick;
        reset = 1'b0;
        start = 1'b0;
        n_checks++; if (state !== 3'd0) $display("FAIL sr_state got %0d want 0", state); else n_pass++;
        n_checks++; if (led !== 3'b011) $display("FAIL sr_led got %b want 011", led); else n_pass++;
        tick;
        n_checks++; if (state !== 3'd0) $display("FAIL sr_state_after got %0d want 0", state); else n_pass++;
    endtask

    task automatic test_degenerate;
        int base;
        base = d_pulses;
        d_start = 1'b1;
        tick;
        d_start = 1'b0;
        n_checks++; if (d_state !== 3'd1) $display("FAIL deg_load got %0d want 1", d_state); else n_pass++;
        tick;
        n_checks++; if (d_state !== 3'd5) $display("FAIL deg_state got %0d want 5", d_state); else n_pass++;
        n_checks++; if (d_led !== 3'b001) $display("FAIL deg_led got %b want 001", d_led); else n_pass++;
        n_checks++; if (d_attempts !== 32'd0) $display("FAIL deg_attempts got %0d want 0", d_attempts); else n_pass++;
        for (int i = 0; i < 4; i++) tick;
        n_checks++; if (d_pulses - base !== 0) $display("FAIL deg_pulses got %0d want 0", d_pulses - base); else n_pass++;
        n_checks++; if (d_state !== 3'd5) $display("FAIL deg_sticky got %0d want 5", d_state); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) bram[i] = '0;
        bram[1] = 128'hA1;
        bram[2] = 128'hA2;
        bram[3] = 128'hA3;
        seen = '0;
        test_reset;
        test_dict_hit;
        test_brute_hit;
        test_full_miss;
        test_backpressure;
        test_reset_mid;
        test_start_ignored;
        test_start_reset;
        test_degenerate;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
